mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage MIPS pipeline.
- Issues one access at a time and counts down the fixed memory latency.
- Returns read data with a one-cycle valid pulse and drives per-stage stall signals to the hazard logic.
- Priority is fixed MEM-over-IF, with a starvation guard so fetch always makes progress.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits.
- MEM_LATENCY, 2, cycles from the Mem_En cycle to valid Mem_RdData; legal range 1..15.
- STARVE_LIMIT, 4, consecutive contested IF losses before IF is forced to win; legal range 1..15.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- IF_Req  in  1  fetch request; held high until IF_Valid.
- IF_Addr  in  ADDR_W  fetch byte address.
- IF_Flush  in  1  cancels an in-flight fetch response (branch or jump redirect).
- IF_Stall  out  1  IF stage must hold.
- IF_Valid  out  1  one-cycle fetch-complete pulse.
- IF_RdData  out  DATA_W  fetched instruction.
- MEM_Req  in  1  load/store request (MemRead|MemWrite); held until MEM_Valid.
- MEM_Write  in  1  1 = store, 0 = load.
- MEM_Addr  in  ADDR_W  data byte address.
- MEM_WrData  in  DATA_W  store data.
- MEM_Stall  out  1  MEM stage must hold.
- MEM_Valid  out  1  one-cycle access-complete pulse.
- MEM_RdData  out  DATA_W  load data; 0 for stores.
- Mem_En  out  1  memory access strobe, one cycle per access.
- Mem_We  out  1  write enable; valid only with Mem_En.
- Mem_Addr  out  ADDR_W  memory address.
- Mem_WrData  out  DATA_W  memory write data.
- Mem_RdData  in  DATA_W  memory read data.

Behaviour:
- Reset: state is IDLE; starvation counter is 0; every output is 0; any in-flight access is dropped with no Valid pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE → ISSUE when any request is high.
  - The grant and the owner's Addr, Write and WrData are latched at this edge.
  - Later changes to request inputs are ignored until the next IDLE.
- ISSUE (1 cycle):
  - Mem_En=1, Mem_We=latched Write (IF grant: Mem_We=0), Mem_Addr and Mem_WrData come from the latches.
  - The latency counter loads MEM_LATENCY-1; go to WAIT.
- WAIT:
  - Mem_En=0 and the counter decrements.
  - When the counter is 0, capture Mem_RdData into the owner's RdData register and go to RESP.
  - Mem_RdData is valid in cycle ISSUE+MEM_LATENCY.
- RESP (1 cycle): the owner's Valid=1 and its Stall=0; next state is IDLE. Requests are not sampled in RESP.
- Latency: a request first seen in IDLE at cycle 0 gets Valid in cycle MEM_LATENCY+2. With the default latency that is cycle 4, so back-to-back accesses occur every MEM_LATENCY+3 cycles.
- Stall: X_Stall = X_Req & ~X_Valid. This is combinational and includes the IDLE cycle in which the request is first seen.
- Priority in IDLE when both requests are high:
  - MEM wins and the starvation counter increments.
  - If the counter == STARVE_LIMIT, IF wins instead.
  - Any IF grant clears the counter. Uncontested grants leave the counter unchanged.
- Stores: MEM_RdData=0 and MEM_Valid pulses in RESP, so stores have the same latency as loads.
- IF_Flush:
  - Sampled every cycle while the owner is IF in ISSUE or WAIT. Any flush sets a cancel flag.
  - In RESP the flag suppresses IF_Valid and IF_RdData does not update.
  - The FSM still completes the latency count.
  - IF_Stall follows IF_Req.
- IF_Flush has no effect in IDLE, or when the owner is MEM.
- Reset asserted in any state: next state is IDLE; the counter and cancel flag are cleared.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- With the macro: adds 32-bit outputs Perf_IFStallCycles and Perf_MEMStallCycles. Each increments every cycle its Stall=1, saturates at 0xFFFFFFFF, and clears on Reset.
- Without the macro: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Single fetch, MEM_LATENCY=2, memory word 0x00000000 = 0x20090001, IF_Req at cycle 0:
  - Required: Mem_En in cycle 1; IF_Valid in cycle 4 only; IF_RdData = 0x20090001; IF_Stall high in cycles 0–3.
- Store followed by load to 0x40:
  - Store 0xDEADBEEF: Mem_We=1 in the ISSUE cycle; MEM_Valid with MEM_RdData=0.
  - Load: MEM_RdData = 0xDEADBEEF.
- Contention with IF_Req and MEM_Req both held, STARVE_LIMIT=2, fresh MEM requests each time:
  - Grant order MEM, MEM, IF, MEM.
  - Counter values 1, 2, 0, 1.
- IF_Flush pulsed in the WAIT cycle of a fetch:
  - No IF_Valid and IF_RdData unchanged.
  - The FSM returns to IDLE on the same cycle count as an unflushed fetch; a pending MEM request is then granted.
- Reset asserted during WAIT of a load:
  - All outputs are 0 next cycle and no MEM_Valid occurs.
  - A re-issued load after reset deassertion completes normally.
- With ARB_PERF_CNT_EN, a single fetch at MEM_LATENCY=2: Perf_IFStallCycles = 4 and Perf_MEMStallCycles = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between IF and MEM (MEM priority, IF starvation guard).
// Optional stall-cycle perf counters are enabled with `define ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IF_Req,
  input  logic [ADDR_W-1:0] IF_Addr,
  input  logic              IF_Flush,
  output logic              IF_Stall,
  output logic              IF_Valid,
  output logic [DATA_W-1:0] IF_RdData,
  input  logic              MEM_Req,
  input  logic              MEM_Write,
  input  logic [ADDR_W-1:0] MEM_Addr,
  input  logic [DATA_W-1:0] MEM_WrData,
  output logic              MEM_Stall,
  output logic              MEM_Valid,
  output logic [DATA_W-1:0] MEM_RdData,
  output logic              Mem_En,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WrData,
  input  logic [DATA_W-1:0] Mem_RdData
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       Perf_IFStallCycles,
  output logic [31:0]       Perf_MEMStallCycles
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            r_state;
  logic              r_own_if, r_we, r_cancel, r_en, r_if_valid, r_mem_valid;
  logic [3:0]        r_lat, r_starve;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_mem_rdata;
  logic              w_grant_if, w_cancel;
  assign w_grant_if = IF_Req & (~MEM_Req | (r_starve == 4'(STARVE_LIMIT)));
  assign w_cancel   = r_cancel | (r_own_if & IF_Flush);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_own_if    <= 1'b0;
      r_we        <= 1'b0;
      r_cancel    <= 1'b0;
      r_en        <= 1'b0;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_lat       <= '0;
      r_starve    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_en        <= 1'b0;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      case (r_state)
        IDLE: if (IF_Req | MEM_Req) begin
          r_state  <= ISSUE;
          r_en     <= 1'b1;
          r_own_if <= w_grant_if;
          r_we     <= ~w_grant_if & MEM_Write;
          r_addr   <= w_grant_if ? IF_Addr : MEM_Addr;
          r_wdata  <= w_grant_if ? '0 : MEM_WrData;
          r_cancel <= 1'b0;
          // only a contested MEM win counts toward starving IF
          r_starve <= w_grant_if ? '0 : IF_Req ? r_starve + 4'd1 : r_starve;
        end
        ISSUE: begin
          r_state  <= WAIT;
          r_lat    <= 4'(MEM_LATENCY - 1);
          r_cancel <= w_cancel;
        end
        WAIT: begin
          r_cancel <= w_cancel;
          if (r_lat == '0) begin
            r_state     <= RESP;
            r_if_valid  <= r_own_if & ~w_cancel;
            r_mem_valid <= ~r_own_if;
            if (r_own_if & ~w_cancel) r_if_rdata <= Mem_RdData;
            if (~r_own_if) r_mem_rdata <= r_we ? '0 : Mem_RdData;
          end else r_lat <= r_lat - 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign Mem_En     = r_en;
  assign Mem_We     = r_en & r_we;
  assign Mem_Addr   = r_addr;
  assign Mem_WrData = r_wdata;
  assign IF_Valid   = r_if_valid;
  assign MEM_Valid  = r_mem_valid;
  assign IF_RdData  = r_if_rdata;
  assign MEM_RdData = r_mem_rdata;
  assign IF_Stall   = IF_Req & ~IF_Valid;
  assign MEM_Stall  = MEM_Req & ~MEM_Valid;
`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Perf_IFStallCycles  <= '0;
      Perf_MEMStallCycles <= '0;
    end else begin
      if (IF_Stall & ~&Perf_IFStallCycles) Perf_IFStallCycles <= Perf_IFStallCycles + 32'd1;
      if (MEM_Stall & ~&Perf_MEMStallCycles) Perf_MEMStallCycles <= Perf_MEMStallCycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboarded directed + random checks of mem_port_arbiter against a latency-accurate memory model.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int SL  = 2;
  logic        Clk = 0, Reset = 1;
  logic        IF_Req = 0, IF_Flush = 0, MEM_Req = 0, MEM_Write = 0;
  logic [31:0] IF_Addr = 0, MEM_Addr = 0, MEM_WrData = 0, Mem_RdData = 0;
  logic        IF_Stall, IF_Valid, MEM_Stall, MEM_Valid, Mem_En, Mem_We;
  logic [31:0] IF_RdData, MEM_RdData, Mem_Addr, Mem_WrData;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] Perf_IFStallCycles, Perf_MEMStallCycles;
`endif
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .Clk(Clk), .Reset(Reset),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Flush(IF_Flush),
    .IF_Stall(IF_Stall), .IF_Valid(IF_Valid), .IF_RdData(IF_RdData),
    .MEM_Req(MEM_Req), .MEM_Write(MEM_Write), .MEM_Addr(MEM_Addr), .MEM_WrData(MEM_WrData),
    .MEM_Stall(MEM_Stall), .MEM_Valid(MEM_Valid), .MEM_RdData(MEM_RdData),
    .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WrData(Mem_WrData),
    .Mem_RdData(Mem_RdData)
`ifdef ARB_PERF_CNT_EN
    , .Perf_IFStallCycles(Perf_IFStallCycles), .Perf_MEMStallCycles(Perf_MEMStallCycles)
`endif
  );
  always #5 Clk = ~Clk;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] mem_arr [64];
  logic [31:0] ref_arr [64];
  logic [31:0] if_q [$];
  logic [31:0] mem_q [$];
  bit          grant_log [$];
  bit          log_on = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // memory presents read data only in cycle ISSUE+LAT; garbage otherwise
  int         m_cnt = 0;
  logic [5:0] m_a = 0;
  always @(negedge Clk) begin
    if (Mem_En) begin
      m_cnt = LAT;
      m_a = Mem_Addr[7:2];
      if (Mem_We) mem_arr[m_a] = Mem_WrData;
      if (log_on) grant_log.push_back(Mem_Addr < 32'h40);
      Mem_RdData = $urandom;
    end else if (m_cnt > 0) begin
      m_cnt--;
      Mem_RdData = (m_cnt == 0) ? mem_arr[m_a] : $urandom;
    end else Mem_RdData = $urandom;
  end
  always @(negedge Clk) if (!Reset) begin
    chk("if_stall_rule", IF_Stall, IF_Req & ~IF_Valid);
    chk("mem_stall_rule", MEM_Stall, MEM_Req & ~MEM_Valid);
    if (IF_Valid) begin
      if (if_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL if_unexpected: IF_Valid with data %0h, none expected", IF_RdData);
      end else chk("if_data", IF_RdData, if_q.pop_front());
    end
    if (MEM_Valid) begin
      if (mem_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL mem_unexpected: MEM_Valid with data %0h, none expected", MEM_RdData);
      end else chk("mem_data", MEM_RdData, mem_q.pop_front());
    end
  end
  task automatic do_if(input logic [31:0] a, output int cyc);
    IF_Req = 1; IF_Addr = a;
    if_q.push_back(ref_arr[a[7:2]]);
    cyc = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      if (IF_Valid) begin cyc = c; break; end
    end
    if (cyc < 0) begin n_cmp++; n_err++; $display("FAIL if_timeout: no IF_Valid for %0h, required within 100", a); end
    @(posedge Clk); #1;
  endtask
  task automatic do_mem(input bit we, input logic [31:0] a, input logic [31:0] d, output int cyc, output bit saw_we);
    MEM_Req = 1; MEM_Write = we; MEM_Addr = a; MEM_WrData = d;
    mem_q.push_back(we ? 32'h0 : ref_arr[a[7:2]]);
    if (we) ref_arr[a[7:2]] = d;
    cyc = -1; saw_we = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      if (Mem_En) saw_we = Mem_We;
      if (MEM_Valid) begin cyc = c; break; end
    end
    if (cyc < 0) begin n_cmp++; n_err++; $display("FAIL mem_timeout: no MEM_Valid for %0h, required within 100", a); end
    @(posedge Clk); #1;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required to finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cyc; bit we;
    logic [10:0] en, mv;
    logic [5:0]  gl;
    logic [31:0] prev;
    bit          ifv;
    for (int i = 0; i < 64; i++) begin mem_arr[i] = $urandom; ref_arr[i] = mem_arr[i]; end
    mem_arr[0] = 32'h20090001; ref_arr[0] = 32'h20090001;
    mem_arr[3] = ~mem_arr[2];  ref_arr[3] = mem_arr[3];
    @(posedge Clk); @(negedge Clk);
    chk("reset_outputs", |{Mem_En, Mem_We, Mem_Addr, Mem_WrData, IF_Valid, MEM_Valid, IF_Stall, MEM_Stall, IF_RdData, MEM_RdData}, 0);
    @(posedge Clk); #1 Reset = 0;
    @(posedge Clk); #1;
    // single fetch: cycle 0 is the first cycle IF_Req is high
    IF_Req = 1; IF_Addr = 0; if_q.push_back(32'h20090001);
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      en[c] = Mem_En; mv[c] = IF_Valid; gl[c] = IF_Stall;
      if (c == 4) begin @(posedge Clk); #1; IF_Req = 0; end
    end
    chk("fetch_mem_en", en[5:0], 6'b000010);
    chk("fetch_valid", mv[5:0], 6'b010000);
    chk("fetch_stall", gl, 6'b001111);
    chk("fetch_rdata", IF_RdData, 32'h20090001);
`ifdef ARB_PERF_CNT_EN
    chk("perf_if", Perf_IFStallCycles, 4);
    chk("perf_mem", Perf_MEMStallCycles, 0);
`endif
    @(posedge Clk); #1;
    do_mem(1, 32'h40, 32'hDEADBEEF, cyc, we);
    chk("store_latency", cyc, 4);
    chk("store_we", we, 1);
    chk("store_rdata", MEM_RdData, 0);
    do_mem(0, 32'h40, 0, cyc, we);
    chk("load_latency", cyc, 4);
    chk("load_we", we, 0);
    chk("load_rdata", MEM_RdData, 32'hDEADBEEF);
    MEM_Req = 0;
    // contention: both held, expect M M I M M I with limit 2
    @(posedge Clk); #1;
    grant_log.delete(); log_on = 1;
    fork
      begin do_if(32'h4, cyc); do_if(32'h8, cyc); IF_Req = 0; end
      begin
        int k; bit w2;
        do_mem(1, 32'h44, $urandom, k, w2); do_mem(0, 32'h44, 0, k, w2);
        do_mem(0, 32'h48, 0, k, w2);        do_mem(1, 32'h4C, $urandom, k, w2);
        MEM_Req = 0;
      end
    join
    log_on = 0;
    chk("grant_count", grant_log.size(), 6);
    gl = '0;
    for (int i = 0; i < 6 && i < grant_log.size(); i++) gl[i] = grant_log[i];
    chk("grant_order", gl, 6'b100100);
    // flush during WAIT with a MEM load arriving meanwhile
    prev = IF_RdData;
    IF_Req = 1; IF_Addr = 32'hC; ifv = 0;
    mem_q.push_back(ref_arr[32'h50 >> 2]);
    for (int c = 0; c < 11; c++) begin
      @(negedge Clk);
      en[c] = Mem_En; mv[c] = MEM_Valid; ifv |= IF_Valid;
      @(posedge Clk); #1;
      if (c == 0) begin MEM_Req = 1; MEM_Write = 0; MEM_Addr = 32'h50; end
      if (c == 1) IF_Flush = 1;
      if (c == 2) begin IF_Flush = 0; IF_Req = 0; end
      if (mv[c]) MEM_Req = 0;
    end
    chk("flush_no_valid", ifv, 0);
    chk("flush_rdata_held", IF_RdData, prev);
    chk("flush_mem_en", en, 11'b00001000010);
    chk("flush_mem_valid", mv, 11'b01000000000);
    // reset in WAIT of a load
    MEM_Req = 1; MEM_Write = 0; MEM_Addr = 32'h54;
    @(posedge Clk); #1;
    @(posedge Clk); #1 Reset = 1; MEM_Req = 0;
    @(posedge Clk); #1 Reset = 0;
    @(negedge Clk);
    chk("wait_reset_outputs", |{Mem_En, Mem_We, Mem_Addr, Mem_WrData, IF_Valid, MEM_Valid, IF_Stall, MEM_Stall, IF_RdData, MEM_RdData}, 0);
`ifdef ARB_PERF_CNT_EN
    chk("perf_reset", |{Perf_IFStallCycles, Perf_MEMStallCycles}, 0);
`endif
    repeat (6) @(negedge Clk);
    @(posedge Clk); #1;
    do_mem(0, 32'h54, 0, cyc, we);
    chk("reload_latency", cyc, 4);
    MEM_Req = 0;
    // random traffic from both stages
    fork
      for (int i = 0; i < 25; i++) begin
        int g, k;
        do_if(32'($urandom_range(0, 15)) << 2, k);
        chk("if_starve_bound", k <= (SL + 2) * (LAT + 3), 1);
        g = $urandom_range(0, 2);
        if (g > 0) begin IF_Req = 0; repeat (g) @(posedge Clk); #1; end
      end
      for (int i = 0; i < 25; i++) begin
        int g, k; bit w2;
        do_mem(1'($urandom_range(0, 1)), 32'h40 + (32'($urandom_range(0, 15)) << 2), $urandom, k, w2);
        g = $urandom_range(0, 2);
        if (g > 0) begin MEM_Req = 0; repeat (g) @(posedge Clk); #1; end
      end
    join
    IF_Req = 0; MEM_Req = 0;
    repeat (10) @(negedge Clk);
    chk("if_q_empty", if_q.size(), 0);
    chk("mem_q_empty", mem_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
